// File: rtl/load_writeback_pkg.sv
// Shared definitions for the load/writeback stage: FSM states and load-size encodings.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package load_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lwb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load faults if its funct3 is not a load size, or its address is not naturally aligned.
  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LB, F3_LBU: load_fault = 1'b0;
      F3_LH, F3_LHU: load_fault = addr_lo[0];
      F3_LW:         load_fault = |addr_lo;
      default:       load_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_writeback_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it to 32 bits.
// Latency: purely combinational.
// Backpressure: none.
module load_extend
  import load_writeback_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by low address bits, then extend according to load size.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Retires one instruction: ALU results write back directly, loads go through a memory read.
// Latency: ALU/faulting load 1 cycle after accept; load 2 + grant wait + rvalid wait cycles.
// Backpressure: in_ready only in IDLE; mem_req/mem_addr held until mem_gnt.
module load_writeback
  import load_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  done,
  output logic                  err
);

  lwb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [DATA_WIDTH-1:0] ext_data;

  load_extend u_extend (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (mem_rdata),
    .data    (ext_data)
  );

  // The read address comes straight from the latched effective address, so it is stable in REQ.
  assign mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign rf_rd    = rf_rd_q;
  assign rf_data  = rf_data_q;

  // Next-state and output decode; rf_rd/rf_data registers only load when entering WB.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    err_d     = err_q;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    in_ready  = 1'b0;
    mem_req   = 1'b0;
    rf_wen    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          rd_d     = in_rd;
          wen_d    = in_wen;
          addr_d   = in_result;
          funct3_d = in_funct3;
          if (in_is_load && !load_fault(in_funct3, in_result[1:0])) begin
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            err_d     = in_is_load;
            rf_rd_d   = in_rd;
            rf_data_d = in_result;
            state_d   = WB;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (mem_rvalid) begin
            rf_rd_d   = rd_q;
            rf_data_d = ext_data;
            state_d   = WB;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rf_rd_d   = rd_q;
          rf_data_d = ext_data;
          state_d   = WB;
        end
      end
      WB: begin
        done    = 1'b1;
        err     = err_q;
        rf_wen  = wen_q && (rd_q != '0) && !err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset abandons any load in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      funct3_q  <= '0;
      err_q     <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      err_q     <= err_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback: directed scenarios plus randomized instructions vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, in_is_load;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [2:0]  in_funct3;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        rf_wen, done, err;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations filled by run_instr
  int          obs_cycles;
  logic        obs_timeout, obs_err, obs_wen, obs_saw_req, obs_addr_bad;
  logic        obs_req_after_gnt, obs_ready_busy, obs_after_pulse;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data, obs_data_after;

  load_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
    .in_result(in_result), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: what a retiring instruction should write, from the ISA load rules.
  function automatic void model(input logic is_load, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] rdata, output logic e, output logic [31:0] d);
    int unsigned off;
    longint unsigned v;
    off = addr % 4;
    e = 1'b0;
    d = addr;
    v = 0;
    if (is_load) begin
      case (f3)
        3'd0, 3'd4: begin
          v = (longint'(rdata) >> (8 * off)) % 256;
          if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
          d = v[31:0];
        end
        3'd1, 3'd5: begin
          e = (off % 2) != 0;
          v = (longint'(rdata) >> (16 * (off / 2))) % 65536;
          if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
          d = v[31:0];
        end
        3'd2: begin
          e = off != 0;
          d = rdata;
        end
        default: e = 1'b1;
      endcase
    end
  endfunction

  // Issue one instruction and act as the memory: grant after gnt_delay REQ cycles,
  // rvalid on the rv_delay-th cycle after grant (0 = together with grant).
  task automatic run_instr(input logic [4:0] rd, input logic wen, input logic [31:0] result,
                           input logic is_load, input logic [2:0] f3,
                           input int gnt_delay, input int rv_delay, input logic [31:0] rdata);
    int   k, cyc, req_n, wait_n;
    logic gnt_done;
    logic [31:0] exp_addr;
    exp_addr = {result[31:2], 2'b00};
    obs_timeout = 0; obs_saw_req = 0; obs_addr_bad = 0; obs_req_after_gnt = 0; obs_ready_busy = 0;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    in_valid = 1'b1; in_rd = rd; in_wen = wen; in_result = result; in_is_load = is_load; in_funct3 = f3;
    @(posedge clk); #1;
    in_valid = 1'b0; in_rd = 5'($urandom); in_wen = 1'($urandom); in_result = $urandom;
    in_is_load = 1'($urandom); in_funct3 = 3'($urandom);
    cyc = 1; req_n = 0; wait_n = 0; gnt_done = 1'b0;
    while (done !== 1'b1 && cyc < 100) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (in_ready === 1'b1) obs_ready_busy = 1'b1;
      if (!gnt_done) begin
        if (mem_req === 1'b1) begin
          obs_saw_req = 1'b1;
          if (mem_addr !== exp_addr) obs_addr_bad = 1'b1;
          if (req_n == gnt_delay) begin
            mem_gnt = 1'b1; gnt_done = 1'b1;
            if (rv_delay == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          end
          req_n++;
        end
      end else begin
        if (mem_req !== 1'b0) obs_req_after_gnt = 1'b1;
        wait_n++;
        if (wait_n == rv_delay) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    obs_timeout = (done !== 1'b1);
    if (in_ready === 1'b1) obs_ready_busy = 1'b1;
    obs_cycles = cyc; obs_err = err; obs_wen = rf_wen; obs_rd = rf_rd; obs_data = rf_data;
    @(posedge clk); #1;
    obs_after_pulse = done | rf_wen | err;
    obs_data_after = rf_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_result = '0; in_is_load = 1'b0;
    in_funct3 = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    n_tests++; if ({in_ready, mem_req, rf_wen, done, err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: ready/req/wen/done/err=%b want 00000", {in_ready, mem_req, rf_wen, done, err}); end
    n_tests++; if (rf_rd !== 5'd0 || rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf: rf_rd=%0d rf_data=%h want 0/0", rf_rd, rf_data); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_alu();
    run_instr(5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 0, 0, 32'd0);
    n_tests++; if (obs_timeout || obs_cycles != 1) begin n_fail++; $display("FAIL alu_latency: cycles=%0d timeout=%b want 1/0", obs_cycles, obs_timeout); end
    n_tests++; if (obs_wen !== 1'b1 || obs_rd !== 5'd5 || obs_data !== 32'h1234_5678 || obs_err !== 1'b0) begin n_fail++; $display("FAIL alu_write: wen=%b rd=%0d data=%h err=%b want 1/5/12345678/0", obs_wen, obs_rd, obs_data, obs_err); end
    n_tests++; if (obs_saw_req || obs_ready_busy) begin n_fail++; $display("FAIL alu_side: req=%b ready_busy=%b want 0/0", obs_saw_req, obs_ready_busy); end
    n_tests++; if (obs_after_pulse !== 1'b0 || obs_data_after !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_after: pulse=%b data=%h want 0/12345678", obs_after_pulse, obs_data_after); end
  endtask

  task automatic test_lb();
    run_instr(5'd7, 1'b1, 32'h0000_1003, 1'b1, 3'b000, 2, 3, 32'h80FF_0011);
    n_tests++; if (obs_timeout || obs_cycles != 7) begin n_fail++; $display("FAIL lb_latency: cycles=%0d timeout=%b want 7/0", obs_cycles, obs_timeout); end
    n_tests++; if (!obs_saw_req || obs_addr_bad || obs_req_after_gnt) begin n_fail++; $display("FAIL lb_mem: req=%b addr_bad=%b req_after_gnt=%b want 1/0/0", obs_saw_req, obs_addr_bad, obs_req_after_gnt); end
    n_tests++; if (obs_data !== 32'hFFFF_FF80 || obs_wen !== 1'b1 || obs_rd !== 5'd7) begin n_fail++; $display("FAIL lb_data: data=%h wen=%b rd=%0d want ffffff80/1/7", obs_data, obs_wen, obs_rd); end
  endtask

  task automatic test_lhu();
    run_instr(5'd9, 1'b1, 32'h0000_2002, 1'b1, 3'b101, 0, 0, 32'hBEEF_1234);
    n_tests++; if (obs_timeout || obs_cycles != 2) begin n_fail++; $display("FAIL lhu_latency: cycles=%0d timeout=%b want 2/0", obs_cycles, obs_timeout); end
    n_tests++; if (obs_data !== 32'h0000_BEEF || obs_wen !== 1'b1 || obs_err !== 1'b0) begin n_fail++; $display("FAIL lhu_data: data=%h wen=%b err=%b want 0000beef/1/0", obs_data, obs_wen, obs_err); end
  endtask

  task automatic test_misaligned();
    run_instr(5'd3, 1'b1, 32'h0000_3001, 1'b1, 3'b010, 0, 0, 32'd0);
    n_tests++; if (obs_saw_req || obs_timeout || obs_cycles != 1) begin n_fail++; $display("FAIL lw_mis_flow: req=%b cycles=%0d want 0/1", obs_saw_req, obs_cycles); end
    n_tests++; if (obs_err !== 1'b1 || obs_wen !== 1'b0) begin n_fail++; $display("FAIL lw_mis_err: err=%b wen=%b want 1/0", obs_err, obs_wen); end
    run_instr(5'd4, 1'b1, 32'h0000_4000, 1'b1, 3'b011, 0, 0, 32'd0);
    n_tests++; if (obs_saw_req || obs_err !== 1'b1 || obs_wen !== 1'b0) begin n_fail++; $display("FAIL illegal_f3: req=%b err=%b wen=%b want 0/1/0", obs_saw_req, obs_err, obs_wen); end
  endtask

  task automatic test_rd0();
    run_instr(5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd0, 0, 0, 32'd0);
    n_tests++; if (obs_timeout || obs_wen !== 1'b0 || obs_err !== 1'b0) begin n_fail++; $display("FAIL rd0: timeout=%b wen=%b err=%b want 0/0/0", obs_timeout, obs_wen, obs_err); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_rd = 5'd10; in_wen = 1'b1; in_result = 32'hAAAA_0001; in_is_load = 1'b0; in_funct3 = 3'd0;
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b1 || rf_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_first: done=%b data=%h want 1/aaaa0001", done, rf_data); end
    in_rd = 5'd11; in_result = 32'hBBBB_0002;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_wb_ready: in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: done=%b ready=%b want 0/1", done, in_ready); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b1 || rf_wen !== 1'b1 || rf_rd !== 5'd11 || rf_data !== 32'hBBBB_0002) begin n_fail++; $display("FAIL b2b_second: done=%b wen=%b rd=%0d data=%h want 1/1/11/bbbb0002", done, rf_wen, rf_rd, rf_data); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait();
    logic bad;
    in_valid = 1'b1; in_rd = 5'd4; in_wen = 1'b1; in_result = 32'h40; in_is_load = 1'b1; in_funct3 = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL rw_req: req=%b addr=%h want 1/00000040", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    n_tests++; if (mem_req !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rw_wait: req=%b ready=%b done=%b want 0/0/0", mem_req, in_ready, done); end
    rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0 || mem_req !== 1'b0 || rf_data !== 32'd0 || rf_rd !== 5'd0) begin n_fail++; $display("FAIL rw_rst_now: ready=%b req=%b rd=%0d data=%h want 0/0/0/0", in_ready, mem_req, rf_rd, rf_data); end
    @(posedge clk); #2;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      if (done !== 1'b0 || rf_wen !== 1'b0) bad = 1'b1;
    end
    mem_rvalid = 1'b0;
    n_tests++; if (bad || in_ready !== 1'b1 || rf_data !== 32'd0) begin n_fail++; $display("FAIL rw_stray: write_or_done=%b ready=%b data=%h want 0/1/0", bad, in_ready, rf_data); end
  endtask

  task automatic test_random();
    logic [4:0]  rd;
    logic        wen, is_load, e, exp_wen;
    logic [2:0]  f3;
    logic [31:0] addr, rdata, d;
    int          gd, rv, exp_cyc;
    for (int it = 0; it < 40; it++) begin
      rd = 5'($urandom_range(0, 31)); wen = 1'($urandom); is_load = ($urandom_range(0, 3) != 0);
      f3 = 3'($urandom_range(0, 7)); addr = $urandom; rdata = $urandom;
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      model(is_load, f3, addr, rdata, e, d);
      exp_wen = wen && (rd != 0) && !e;
      exp_cyc = (is_load && !e) ? 2 + gd + rv : 1;
      run_instr(rd, wen, addr, is_load, f3, gd, rv, rdata);
      n_tests++; if (obs_timeout || obs_cycles != exp_cyc) begin n_fail++; $display("FAIL rnd_latency[%0d]: cycles=%0d want %0d", it, obs_cycles, exp_cyc); end
      n_tests++; if (obs_err !== e || obs_wen !== exp_wen) begin n_fail++; $display("FAIL rnd_flags[%0d]: err=%b wen=%b want %b/%b", it, obs_err, obs_wen, e, exp_wen); end
      if (exp_wen) begin
        n_tests++; if (obs_data !== d || obs_rd !== rd) begin n_fail++; $display("FAIL rnd_data[%0d]: rd=%0d data=%h want %0d/%h", it, obs_rd, obs_data, rd, d); end
      end
      n_tests++; if (obs_saw_req !== (is_load && !e) || obs_addr_bad || obs_req_after_gnt) begin n_fail++; $display("FAIL rnd_mem[%0d]: req=%b addr_bad=%b req_after_gnt=%b want %b/0/0", it, obs_saw_req, obs_addr_bad, obs_req_after_gnt, is_load && !e); end
      n_tests++; if (obs_ready_busy || obs_after_pulse) begin n_fail++; $display("FAIL rnd_pulse[%0d]: ready_busy=%b after_pulse=%b want 0/0", it, obs_ready_busy, obs_after_pulse); end
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        n_tests++; if (done !== 1'b0 || rf_wen !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_idle_rvalid[%0d]: done=%b wen=%b ready=%b want 0/0/1", it, done, rf_wen, in_ready); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu();
    test_misaligned();
    test_rd0();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_writeback.md
LOAD_WRITEBACK -- requirements
Module: load_writeback

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width (matches register file).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  execute stage presents a retiring instruction.
REQ-006 SHALL have port in_ready  output  1  block can accept; high only in IDLE with rst low.
REQ-007 SHALL have port in_rd  input  ADDR_WIDTH  destination register index.
REQ-008 SHALL have port in_wen  input  1  instruction writes rd.
REQ-009 SHALL have port in_result  input  DATA_WIDTH  ALU result, or effective address when in_is_load.
REQ-010 SHALL have port in_is_load  input  1  instruction is a load.
REQ-011 SHALL have port in_funct3  input  3  load size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-012 SHALL have port mem_req  output  1  data-memory read request.
REQ-013 SHALL have port mem_addr  output  DATA_WIDTH  word-aligned read address {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_gnt  input  1  memory accepted the request.
REQ-015 SHALL have port mem_rvalid  input  1  mem_rdata valid.
REQ-016 SHALL have port mem_rdata  input  DATA_WIDTH  full aligned word read.
REQ-017 SHALL have ports rf_wen/rf_rd/rf_data  output  1/ADDR_WIDTH/DATA_WIDTH  register-file write port.
REQ-018 SHALL have port done  output  1  one-cycle pulse: instruction retired (PC may advance).
REQ-019 SHALL have port err  output  1  one-cycle pulse with done: misaligned or illegal-funct3 load.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, WB.
REQ-021 SHALL accept on in_valid && in_ready, latching rd, wen, result, is_load, funct3.
REQ-022 IDLE accept, non-load -> WB; write occurs the cycle after acceptance (latency 1).
REQ-023 IDLE accept, legal aligned load -> REQ; misaligned (lh/lhu addr[0]=1, lw addr[1:0]!=0) or funct3 in {011,110,111} -> WB with err set.
REQ-024 REQ: mem_req=1 and mem_addr held stable until mem_gnt; gnt without rvalid -> WAIT; gnt with rvalid same cycle -> capture, WB.
REQ-025 WAIT: mem_req=0; stay until mem_rvalid; then capture extended data, WB.
REQ-026 mem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-027 Extension: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
REQ-028 WB lasts exactly one cycle: done=1; rf_wen = latched wen && rd!=0 && !err; rf_rd/rf_data driven from latches; then IDLE.
REQ-029 Outside WB rf_wen, done, err SHALL be 0; rf_rd/rf_data hold last value.
REQ-030 in_ready SHALL be 0 in REQ, WAIT, WB; back-to-back instructions therefore accepted every 2 cycles minimum.

Reset
REQ-031 rst high SHALL immediately force IDLE, mem_req=0, rf_wen=0, done=0, err=0, in_ready=0, rf_rd=0, rf_data=0, latches 0.
REQ-032 Reset during REQ/WAIT SHALL abandon the load; a later mem_rvalid SHALL NOT cause a write.

Structure
REQ-033 FSM state encodings and load funct3 constants SHALL live in the shared LemonPC package/include.
REQ-034 Byte/half select and extension SHALL be a combinational sub-module load_extend (inputs funct3, addr[1:0], rdata; output data).

Verification
REQ-035 ALU op: rd=5, wen=1, result=0x12345678 -> next cycle rf_wen=1, rf_rd=5, rf_data=0x12345678, done=1.
REQ-036 lb addr 0x1003, gnt after 2 cycles, rvalid 3 cycles later, rdata=0x80FF0011 -> mem_addr 0x1000 held during REQ, rf_data=0xFFFFFF80.
REQ-037 lhu addr 0x2002, gnt+rvalid same cycle, rdata=0xBEEF1234 -> rf_data=0x0000BEEF, no WAIT cycle.
REQ-038 lw addr 0x3001 -> no mem_req, next cycle done=1, err=1, rf_wen=0.
REQ-039 ALU op with rd=0 -> done=1, rf_wen=0.
REQ-040 rst pulse during WAIT, then stray rvalid -> IDLE, no rf_wen, no done.
